// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: round-robin arbiter for N requesters with a bounded grant-hold window.
// The grant is registered and one-hot. The binary owner index and the valid flag come
// from the same registers. A requester keeps the grant while it keeps requesting, up to
// HOLD_MAX cycles. After that, or once it drops its request, priority rotates past it.
`timescale 1ns/1ps

module rr_arbiter_n #(
    parameter  int N        = 4,          // number of requesters, 2..32
    parameter  int HOLD_MAX = 8,          // max consecutive grant cycles, 0 = unlimited
    localparam int IW       = $clog2(N)   // width of gnt_id
) (
    input  logic          clk,
    input  logic          rst,            // asynchronous, active-high
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          gnt_valid
);

    // The hold counter only has to reach HOLD_MAX.
    // In unlimited mode a single saturating bit is enough.
    localparam int             CW       = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0]  HOLD_LIM = CW'(HOLD_MAX);
    localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    // Index of the lowest set bit of v. Returns 0 when v is empty; callers gate on |v.
    function automatic logic [IW-1:0] lowest_set(input logic [N-1:0] v);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IW'(i);
            end
        end
        return idx;
    endfunction

    // Increment modulo N. This keeps non-power-of-2 N away from indices >= N.
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
        return (x == LAST_IDX) ? '0 : x + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t         r_state;
    logic [IW-1:0]  r_owner;
    logic [IW-1:0]  r_ptr;
    logic [CW-1:0]  r_hold_cnt;
    logic [N-1:0]   r_gnt;

    // ------------------------------------------------------------------
    // Combinational arbitration
    // ------------------------------------------------------------------
    logic [IW-1:0]  w_scan_base;    // first index with top priority this cycle
    logic [N-1:0]   w_upper_mask;   // bits at or above the scan base
    logic [N-1:0]   w_req_upper;    // requests that win before the scan wraps
    logic           w_req_any;
    logic [IW-1:0]  w_win_idx;      // arb(req, w_scan_base)
    logic [N-1:0]   w_win_onehot;
    logic           w_window_ok;    // hold window not yet exhausted
    logic           w_keep;         // current owner keeps the grant
    logic [CW-1:0]  w_hold_inc;

    // Idle: scan from the stored pointer. At release: scan from the slot after the
    // owner, so the outgoing owner gets the lowest priority.
    always_comb begin
        w_scan_base = r_ptr;
        if (r_state == S_GRANT) begin
            w_scan_base = wrap_inc(r_owner);
        end
    end

    // The rotating scan is split into two passes. The "upper" pass covers requests
    // at index >= base. If none is found, the lowest request overall is the
    // wrapped-around winner.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_mask
            assign w_upper_mask[gi] = (IW'(gi) >= w_scan_base);
            assign w_win_onehot[gi] = (w_win_idx == IW'(gi));
        end
    endgenerate

    assign w_req_upper = req & w_upper_mask;
    assign w_req_any   = |req;

    // Pick the winner: the first request at or above base, otherwise the first from 0.
    always_comb begin
        if (|w_req_upper) begin
            w_win_idx = lowest_set(w_req_upper);
        end else begin
            w_win_idx = lowest_set(req);
        end
    end

    // Keep decision: the owner still requests and its hold window is still open.
    always_comb begin
        w_window_ok = (HOLD_MAX == 0) || (r_hold_cnt < HOLD_LIM);
        w_keep      = (r_state == S_GRANT) && req[r_owner] && w_window_ok;
    end

    // Hold counter step. It saturates in unlimited mode and never wraps to zero.
    always_comb begin
        w_hold_inc = r_hold_cnt + 1'b1;
        if ((HOLD_MAX == 0) && (&r_hold_cnt)) begin
            w_hold_inc = r_hold_cnt;
        end
    end

    // Arbiter FSM. Grant, owner, pointer and hold count all update together here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_gnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_state    <= S_GRANT;
                        r_owner    <= w_win_idx;
                        r_gnt      <= w_win_onehot;
                        r_hold_cnt <= CW'(1);
                        r_ptr      <= wrap_inc(w_win_idx);
                    end
                end
                S_GRANT: begin
                    if (w_keep) begin
                        r_hold_cnt <= w_hold_inc;
                    end else if (w_req_any) begin
                        // Back-to-back handover. This may be the same owner again
                        // when it is the only requester left.
                        r_owner    <= w_win_idx;
                        r_gnt      <= w_win_onehot;
                        r_hold_cnt <= CW'(1);
                        r_ptr      <= wrap_inc(w_win_idx);
                    end else begin
                        // Nobody left. The pointer keeps the value from the last grant.
                        r_state    <= S_IDLE;
                        r_gnt      <= '0;
                        r_hold_cnt <= '0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_gnt      <= '0;
                    r_hold_cnt <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all taken straight from the grant registers
    // ------------------------------------------------------------------
    assign gnt       = r_gnt;
    assign gnt_id    = r_owner;
    assign gnt_valid = |r_gnt;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Testbench for rr_arbiter_n with three configurations: N=4/H=4, N=4/H=0 and N=5/H=3.
// Hand-derived vector table plus directed corner sequences, then randomized
// requests compared against a simple behavioural model.
`timescale 1ns/1ps

module tb_rr_arbiter_n;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Instance A: N=4, HOLD_MAX=4
    logic [3:0] req_a, gnt_a;
    logic [1:0] id_a;
    logic       val_a;
    // Instance B: N=4, HOLD_MAX=0 (unlimited)
    logic [3:0] req_b, gnt_b;
    logic [1:0] id_b;
    logic       val_b;
    // Instance C: N=5, HOLD_MAX=3 (non-power-of-2 wrap)
    logic [4:0] req_c, gnt_c;
    logic [2:0] id_c;
    logic       val_c;

    rr_arbiter_n #(.N(4), .HOLD_MAX(4)) u_a (
        .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .gnt_id(id_a), .gnt_valid(val_a)
    );
    rr_arbiter_n #(.N(4), .HOLD_MAX(0)) u_b (
        .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .gnt_id(id_b), .gnt_valid(val_b)
    );
    rr_arbiter_n #(.N(5), .HOLD_MAX(3)) u_c (
        .clk(clk), .rst(rst), .req(req_c), .gnt(gnt_c), .gnt_id(id_c), .gnt_valid(val_c)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input logic [3:0] r, input logic [3:0] g, input logic [1:0] i);
        vec_t v;
        v.req = r;
        v.gnt = g;
        v.id  = i;
        vecs.push_back(v);
    endfunction

    // ---------------- behavioural model ----------------
    // owner < 0 means idle. The grant goes to the first requester found going round
    // from the start slot. That slot is ptr when idle, or the owner's successor
    // when a grant is released.
    typedef struct {
        int owner;
        int ptr;
        int cnt;
    } mstate_t;

    function automatic bit bit_at(input logic [31:0] v, input int i);
        logic [31:0] s;
        s = v >> i;
        return s[0];
    endfunction

    function automatic mstate_t mstep(input mstate_t s, input logic [31:0] r, input int n, input int h);
        mstate_t t;
        int start;
        int win;
        t   = s;
        win = -1;
        if (s.owner >= 0 && bit_at(r, s.owner) && (h == 0 || s.cnt < h)) begin
            t.cnt = s.cnt + 1;
            return t;
        end
        start = (s.owner < 0) ? s.ptr : (s.owner + 1) % n;
        for (int k = 0; k < n; k++) begin
            if (win < 0 && bit_at(r, (start + k) % n)) win = (start + k) % n;
        end
        if (win < 0) begin
            t.owner = -1;
        end else begin
            t.owner = win;
            t.cnt   = 1;
            t.ptr   = (win + 1) % n;
        end
        return t;
    endfunction

    function automatic logic [31:0] mgnt(input mstate_t s);
        return (s.owner < 0) ? 32'd0 : (32'd1 << s.owner);
    endfunction

    function automatic mstate_t mreset();
        mstate_t s;
        s.owner = -1;
        s.ptr   = 0;
        s.cnt   = 0;
        return s;
    endfunction

    mstate_t ma, mb, mc;

    initial begin
        req_a = '0;
        req_b = '0;
        req_c = '0;

        // ---------------- reset state ----------------
        #1 rst = 1'b1;
        #1;
        check("rst gnt_a", 32'(gnt_a), 32'd0);
        check("rst id_a", 32'(id_a), 32'd0);
        check("rst val_a", 32'(val_a), 32'd0);
        check("rst gnt_b", 32'(gnt_b), 32'd0);
        check("rst val_b", 32'(val_b), 32'd0);
        check("rst gnt_c", 32'(gnt_c), 32'd0);
        check("rst id_c", 32'(id_c), 32'd0);
        check("rst val_c", 32'(val_c), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // ---------------- table (instance A, N=4 H=4) ----------------
        // all four requesting: 4 cycles each in rotation, then wrap to requester 0
        for (int i = 0; i < 16; i++) add_vec(4'b1111, 4'(1 << (i / 4)), 2'(i / 4));
        add_vec(4'b1111, 4'b0001, 2'd0);
        add_vec(4'b0000, 4'b0000, 2'd0);
        // single-cycle request from 2, then ptr=3 so requester 3 wins next
        add_vec(4'b0100, 4'b0100, 2'd2);
        add_vec(4'b0000, 4'b0000, 2'd0);
        add_vec(4'b1111, 4'b1000, 2'd3);
        add_vec(4'b0000, 4'b0000, 2'd0);
        // only requester 3 for 10 cycles: the grant never drops across hold expiries
        for (int i = 0; i < 10; i++) add_vec(4'b1000, 4'b1000, 2'd3);
        add_vec(4'b0000, 4'b0000, 2'd0);
        // owner 1 drops while 0 and 2 request: 2 wins, then 0
        add_vec(4'b0010, 4'b0010, 2'd1);
        add_vec(4'b0111, 4'b0010, 2'd1);
        add_vec(4'b0101, 4'b0100, 2'd2);
        add_vec(4'b0101, 4'b0100, 2'd2);
        add_vec(4'b0001, 4'b0001, 2'd0);
        add_vec(4'b0000, 4'b0000, 2'd0);

        foreach (vecs[k]) begin
            req_a = vecs[k].req;
            tick();
            check($sformatf("vec%0d gnt", k), 32'(gnt_a), 32'(vecs[k].gnt));
            check($sformatf("vec%0d valid", k), 32'(val_a), 32'(vecs[k].gnt != 4'b0000));
            if (vecs[k].gnt != 4'b0000)
                check($sformatf("vec%0d id", k), 32'(id_a), 32'(vecs[k].id));
            $display("vec %0d req=%b gnt=%b id=%0d valid=%0d", k, req_a, gnt_a, id_a, val_a);
        end

        // ---------------- asynchronous reset mid-grant ----------------
        req_a = 4'b0100;
        tick();
        check("pre-rst gnt", 32'(gnt_a), 32'b0100);
        #3 rst = 1'b1;
        #1;
        check("async rst gnt", 32'(gnt_a), 32'd0);
        check("async rst valid", 32'(val_a), 32'd0);
        check("async rst id", 32'(id_a), 32'd0);
        $display("reset mid-grant gnt=%b valid=%0d", gnt_a, val_a);
        req_a = 4'b1010;
        tick();
        tick();
        check("held rst gnt", 32'(gnt_a), 32'd0);
        rst = 1'b0;
        tick();
        check("post-rst gnt", 32'(gnt_a), 32'b0010);
        check("post-rst id", 32'(id_a), 32'd1);
        $display("after reset req=%b gnt=%b", req_a, gnt_a);
        req_a = '0;
        tick();

        // ---------------- unlimited hold (instance B) ----------------
        req_b = 4'b0011;
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("h0 hold%0d", i), 32'(gnt_b), 32'b0001);
        end
        $display("h0 held 20 cycles gnt=%b", gnt_b);
        req_b = 4'b0010;
        tick();
        check("h0 move gnt", 32'(gnt_b), 32'b0010);
        check("h0 move id", 32'(id_b), 32'd1);
        $display("h0 release req=%b gnt=%b", req_b, gnt_b);
        req_b = '0;
        tick();
        check("h0 idle valid", 32'(val_b), 32'd0);

        // ---------------- wrap on N=5 after hold expiry (instance C) ----------------
        req_c = 5'b10000;
        tick();
        check("n5 gnt4", 32'(gnt_c), 32'b10000);
        check("n5 id4", 32'(id_c), 32'd4);
        req_c = 5'b10001;
        tick();
        check("n5 keep1", 32'(gnt_c), 32'b10000);
        tick();
        check("n5 keep2", 32'(gnt_c), 32'b10000);
        tick();
        check("n5 wrap gnt", 32'(gnt_c), 32'b00001);
        check("n5 wrap id", 32'(id_c), 32'd0);
        $display("n5 wrap req=%b gnt=%b id=%0d", req_c, gnt_c, id_c);
        req_c = '0;
        tick();

        // ---------------- randomized against model ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ma = mreset();
        mb = mreset();
        mc = mreset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            req_a = req_a ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            req_b = req_b ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            req_c = req_c ^ (5'($urandom) & 5'($urandom) & 5'($urandom));
            if ($urandom_range(0, 19) == 0) req_a = '0;
            if ($urandom_range(0, 19) == 0) req_b = '0;
            if ($urandom_range(0, 19) == 0) req_c = '0;
            tick();
            ma = mstep(ma, 32'(req_a), 4, 4);
            mb = mstep(mb, 32'(req_b), 4, 0);
            mc = mstep(mc, 32'(req_c), 5, 3);
            check($sformatf("rnd%0d gnt_a", cyc), 32'(gnt_a), mgnt(ma));
            check($sformatf("rnd%0d val_a", cyc), 32'(val_a), 32'(ma.owner >= 0));
            if (ma.owner >= 0) check($sformatf("rnd%0d id_a", cyc), 32'(id_a), 32'(ma.owner));
            check($sformatf("rnd%0d gnt_b", cyc), 32'(gnt_b), mgnt(mb));
            check($sformatf("rnd%0d val_b", cyc), 32'(val_b), 32'(mb.owner >= 0));
            if (mb.owner >= 0) check($sformatf("rnd%0d id_b", cyc), 32'(id_b), 32'(mb.owner));
            check($sformatf("rnd%0d gnt_c", cyc), 32'(gnt_c), mgnt(mc));
            check($sformatf("rnd%0d val_c", cyc), 32'(val_c), 32'(mc.owner >= 0));
            if (mc.owner >= 0) check($sformatf("rnd%0d id_c", cyc), 32'(id_c), 32'(mc.owner));
            $display("rnd %0d a:%b->%b b:%b->%b c:%b->%b", cyc, req_a, gnt_a, req_b, gnt_b, req_c, gnt_c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
